// File: rtl/card_row_renderer.sv
// Pixel stage that maps VGA counters onto a row of card slots and colours the result.
// Three register stages: ROM address, ROM read, final colour; sync/valid ride alongside.
module card_row_renderer #(
    parameter int          CARD_W      = 32,
    parameter int          CARD_H      = 46,
    parameter int          NUM_SLOTS   = 20,
    parameter int          NUM_SPRITES = 20,
    parameter int          ROW_X       = 0,
    parameter int          ROW_Y       = 200,
    parameter logic [11:0] BG_COLOR    = 12'h063,
    parameter logic [11:0] TRANSP      = 12'hF0F,
    parameter logic [11:0] HL_COLOR    = 12'hFF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [4:0]  wr_slot,
    input  logic [4:0]  wr_card,
    input  logic [4:0]  sel_slot,
    output logic [14:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [11:0] rgb,
    output logic        valid_out,
    output logic        hsync_out,
    output logic        vsync_out
);
    localparam int CW_LOG = $clog2(CARD_W);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [4:0]        tbl_q [NUM_SLOTS];
    logic [9:0]        dx, dy, slot;
    logic [CW_LOG-1:0] px;
    logic [4:0]        id;
    logic              in_row, draw, border;
    logic [14:0]       addr_d, rom_addr_q;
    logic [1:0]        draw_pipe_q, border_pipe_q;
    logic [2:0]        vld_pipe_q, hs_pipe_q, vs_pipe_q;
    logic [11:0]       rgb_d, rgb_q;

    // S1: pixel position -> slot, sprite offset and ROM address
    always_comb begin
        dx     = h_cnt - 10'(ROW_X);
        dy     = v_cnt - 10'(ROW_Y);
        slot   = dx >> CW_LOG;
        px     = dx[CW_LOG-1:0];
        in_row = (int'(h_cnt) >= ROW_X) && (int'(v_cnt) >= ROW_Y) &&
                 (int'(dy) < CARD_H) && (int'(slot) < NUM_SLOTS);
        id     = in_row ? tbl_q[slot[SLOT_W-1:0]] : 5'h1F;
        draw   = valid_in && in_row && (int'(id) < NUM_SPRITES);
        border = in_row && (slot == 10'(sel_slot)) &&
                 (px == '0 || px == {CW_LOG{1'b1}} || dy == '0 || int'(dy) == CARD_H - 1);
        addr_d = draw ? 15'(id) * 15'(CARD_W * CARD_H) + (15'(dy) << CW_LOG) + 15'(px) : '0;
    end

    // S3: colour select on the registered ROM word
    always_comb begin
        rgb_d = '0;
        if (vld_pipe_q[1]) begin
            if (border_pipe_q[1])
                rgb_d = HL_COLOR;
            else if (!draw_pipe_q[1] || rom_data == TRANSP)
                rgb_d = BG_COLOR;
            else
                rgb_d = rom_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr_q    <= '0;
            draw_pipe_q   <= '0;
            border_pipe_q <= '0;
            vld_pipe_q    <= '0;
            hs_pipe_q     <= '1;
            vs_pipe_q     <= '1;
            rgb_q         <= '0;
        end else begin
            rom_addr_q    <= addr_d;
            draw_pipe_q   <= {draw_pipe_q[0], draw};
            border_pipe_q <= {border_pipe_q[0], border};
            vld_pipe_q    <= {vld_pipe_q[1:0], valid_in};
            hs_pipe_q     <= {hs_pipe_q[1:0], hsync_in};
            vs_pipe_q     <= {vs_pipe_q[1:0], vsync_in};
            rgb_q         <= rgb_d;
        end
    end

    // Table is read combinationally above, so a same-edge write is seen one pixel later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) tbl_q[i] <= 5'h1F;
        end else if (wr_en && int'(wr_slot) < NUM_SLOTS) begin
            tbl_q[wr_slot[SLOT_W-1:0]] <= wr_card;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rgb       = rgb_q;
    assign valid_out = vld_pipe_q[2];
    assign hsync_out = hs_pipe_q[2];
    assign vsync_out = vs_pipe_q[2];
endmodule
